// File: rtl/hud_text_sequencer_if.sv
// rtl/hud_text_sequencer_if.sv - game-logic <-> HUD text sequencer signal bundle
// Hi-score digit signals exist only when HUD_HISCORE_EN is defined.
interface hud_text_sequencer_if #(
    parameter int SCORE_W = 10
);
    logic               frame_clk;
    logic               start_game;
    logic               pacman_dead;
    logic [SCORE_W-1:0] score;
    logic               show_title;
    logic               show_score;
    logic               show_game_over;
    logic [7:0]         digit_h;
    logic [7:0]         digit_t;
    logic [7:0]         digit_u;
    logic               digits_busy;
    logic [1:0]         game_state;
`ifdef HUD_HISCORE_EN
    logic [7:0]         hi_h;
    logic [7:0]         hi_t;
    logic [7:0]         hi_u;
`endif

    modport master (
        output frame_clk, start_game, pacman_dead, score,
        input  show_title, show_score, show_game_over,
        input  digit_h, digit_t, digit_u, digits_busy, game_state
`ifdef HUD_HISCORE_EN
        , input hi_h, hi_t, hi_u
`endif
    );

    modport slave (
        input  frame_clk, start_game, pacman_dead, score,
        output show_title, show_score, show_game_over,
        output digit_h, digit_t, digit_u, digits_busy, game_state
`ifdef HUD_HISCORE_EN
        , output hi_h, hi_t, hi_u
`endif
    );
endinterface

// File: rtl/hud_text_sequencer.sv
// rtl/hud_text_sequencer.sv - HUD banner FSM, blink/hold timers and score-to-ASCII converter
// Optional hi-score tracking is enabled by defining HUD_HISCORE_EN.
module hud_text_sequencer #(
    parameter int SCORE_W         = 10,
    parameter int SCORE_MAX       = 999,
    parameter int BLINK_FRAMES    = 30,
    parameter int GAMEOVER_FRAMES = 180
) (
    input logic                   Clk,
    input logic                   Reset_n,
    hud_text_sequencer_if.slave   bus
);
    localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam int GW = (GAMEOVER_FRAMES > 1) ? $clog2(GAMEOVER_FRAMES) : 1;
    localparam int CW = (SCORE_W > 1) ? $clog2(SCORE_W) : 1;
    localparam logic [BW-1:0]      BLINK_LAST = BW'(BLINK_FRAMES - 1);
    localparam logic [GW-1:0]      HOLD_LAST  = GW'(GAMEOVER_FRAMES - 1);
    localparam logic [CW-1:0]      SHIFT_LAST = CW'(SCORE_W - 1);
    localparam logic [SCORE_W-1:0] SAT        = SCORE_W'(SCORE_MAX);

    typedef enum logic [1:0] {
        ST_TITLE     = 2'b00,
        ST_PLAY      = 2'b01,
        ST_GAME_OVER = 2'b10
    } state_t;

    state_t             r_state;
    logic               r_frame_q;
    logic               r_show_title;
    logic               r_show_score;
    logic               r_show_go;
    logic [BW-1:0]      r_blink_cnt;
    logic [GW-1:0]      r_hold_cnt;
    logic               r_busy;
    logic [SCORE_W-1:0] r_bin;
    logic [11:0]        r_bcd;
    logic [CW-1:0]      r_shift_cnt;
    logic [7:0]         r_digit_h;
    logic [7:0]         r_digit_t;
    logic [7:0]         r_digit_u;

    logic               w_tick;
    logic [SCORE_W-1:0] w_score_sat;
    logic [11:0]        w_bcd_adj;
    logic [11:0]        w_bcd_next;

    assign w_tick      = bus.frame_clk & ~r_frame_q;
    assign w_score_sat = (bus.score > SAT) ? SAT : bus.score;

    always_comb begin
        w_bcd_adj = r_bcd;
        for (int i = 0; i < 3; i++) begin
            if (r_bcd[4*i +: 4] >= 4'd5)
                w_bcd_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
        end
    end
    assign w_bcd_next = {w_bcd_adj[10:0], r_bin[SCORE_W-1]};

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) r_frame_q <= 1'b0;
        else          r_frame_q <= bus.frame_clk;
    end

    // Banner outputs are updated alongside the state so they never lag it by a cycle.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state      <= ST_TITLE;
            r_show_title <= 1'b1;
            r_show_score <= 1'b0;
            r_show_go    <= 1'b0;
            r_blink_cnt  <= '0;
            r_hold_cnt   <= '0;
        end else begin
            case (r_state)
                ST_TITLE: begin
                    if (bus.start_game) begin
                        r_state      <= ST_PLAY;
                        r_blink_cnt  <= '0;
                        r_show_title <= 1'b0;
                        r_show_score <= 1'b1;
                    end else if (w_tick) begin
                        if (r_blink_cnt == BLINK_LAST) begin
                            r_blink_cnt  <= '0;
                            r_show_title <= ~r_show_title;
                        end else begin
                            r_blink_cnt <= r_blink_cnt + BW'(1);
                        end
                    end
                end
                ST_PLAY: begin
                    if (bus.pacman_dead) begin
                        r_state    <= ST_GAME_OVER;
                        r_hold_cnt <= '0;
                        r_show_go  <= 1'b1;
                    end
                end
                ST_GAME_OVER: begin
                    if (w_tick) begin
                        if (r_hold_cnt == HOLD_LAST) begin
                            r_state      <= ST_TITLE;
                            r_hold_cnt   <= '0;
                            r_blink_cnt  <= '0;
                            r_show_title <= 1'b1;
                            r_show_score <= 1'b0;
                            r_show_go    <= 1'b0;
                        end else begin
                            r_hold_cnt <= r_hold_cnt + GW'(1);
                        end
                    end
                end
                default: begin
                    r_state      <= ST_TITLE;
                    r_show_title <= 1'b1;
                    r_show_score <= 1'b0;
                    r_show_go    <= 1'b0;
                end
            endcase
        end
    end

    // Double-dabble: digits are written only on the final shift, never mid-conversion.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_busy      <= 1'b0;
            r_bin       <= '0;
            r_bcd       <= '0;
            r_shift_cnt <= '0;
            r_digit_h   <= 8'h30;
            r_digit_t   <= 8'h30;
            r_digit_u   <= 8'h30;
        end else if (!r_busy) begin
            if (w_tick) begin
                r_bin       <= w_score_sat;
                r_bcd       <= '0;
                r_shift_cnt <= '0;
                r_busy      <= 1'b1;
            end
        end else begin
            r_bcd       <= w_bcd_next;
            r_bin       <= {r_bin[SCORE_W-2:0], 1'b0};
            r_shift_cnt <= r_shift_cnt + CW'(1);
            if (r_shift_cnt == SHIFT_LAST) begin
                r_busy    <= 1'b0;
                r_digit_h <= {4'h3, w_bcd_next[11:8]};
                r_digit_t <= {4'h3, w_bcd_next[7:4]};
                r_digit_u <= {4'h3, w_bcd_next[3:0]};
            end
        end
    end

    assign bus.show_title     = r_show_title;
    assign bus.show_score     = r_show_score;
    assign bus.show_game_over = r_show_go;
    assign bus.digit_h        = r_digit_h;
    assign bus.digit_t        = r_digit_t;
    assign bus.digit_u        = r_digit_u;
    assign bus.digits_busy    = r_busy;
    assign bus.game_state     = r_state;

`ifdef HUD_HISCORE_EN
    logic [SCORE_W-1:0] r_hi_score;
    logic [7:0]         r_hi_h;
    logic [7:0]         r_hi_t;
    logic [7:0]         r_hi_u;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_hi_score <= '0;
            r_hi_h     <= 8'h30;
            r_hi_t     <= 8'h30;
            r_hi_u     <= 8'h30;
        end else if (r_state == ST_PLAY && bus.pacman_dead && w_score_sat > r_hi_score) begin
            r_hi_score <= w_score_sat;
            r_hi_h     <= r_digit_h;
            r_hi_t     <= r_digit_t;
            r_hi_u     <= r_digit_u;
        end
    end

    assign bus.hi_h = r_hi_h;
    assign bus.hi_t = r_hi_t;
    assign bus.hi_u = r_hi_u;
`endif
endmodule

// File: tb/tb_hud_text_sequencer.sv
// tb/tb_hud_text_sequencer.sv - scoreboard bench for hud_text_sequencer
module tb_hud_text_sequencer;
    logic Clk = 1'b0;
    logic Reset_n;
    always #5 Clk = ~Clk;

    hud_text_sequencer_if #(.SCORE_W(10)) bus ();

    hud_text_sequencer #(
        .SCORE_W(10), .SCORE_MAX(999), .BLINK_FRAMES(30), .GAMEOVER_FRAMES(180)
    ) dut (
        .Clk(Clk), .Reset_n(Reset_n), .bus(bus)
    );

    typedef struct {
        logic [23:0] dig;
        int          c;
    } exp_t;

    exp_t        q[$];
    exp_t        e;
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          last_acc = -1000;
    logic [23:0] cur;
    logic [23:0] prev_dig = 24'h303030;
    logic        prev_busy = 1'b0;

    always @(posedge Clk) cyc <= cyc + 1;

    function automatic logic [23:0] ref_digits(input int s);
        int v;
        v = (s > 999) ? 999 : s;
        return {8'(48 + v / 100), 8'(48 + (v / 10) % 10), 8'(48 + v % 10)};
    endfunction

    task automatic chk(input string nm, input int act, input int exp_v);
        total++;
        if (act != exp_v) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp_v);
        end
    endtask

    // A tick latched at edge c starts a conversion only if the previous one finished (10 shifts).
    task automatic model_tick(input int c);
        exp_t n;
        if (c > last_acc + 10) begin
            last_acc = c;
            n.dig = ref_digits(int'(bus.score));
            n.c   = c;
            q.push_back(n);
        end
    endtask

    task automatic do_tick(input int gap);
        @(negedge Clk);
        bus.frame_clk = 1'b1;
        model_tick(cyc + 1);
        @(negedge Clk);
        bus.frame_clk = 1'b0;
        repeat (gap) @(negedge Clk);
    endtask

    task automatic pulse(input logic st, input logic dd);
        @(negedge Clk);
        bus.start_game  = st;
        bus.pacman_dead = dd;
        @(negedge Clk);
        bus.start_game  = 1'b0;
        bus.pacman_dead = 1'b0;
    endtask

    task automatic async_reset_check(input string tag);
        @(negedge Clk);
        #2 Reset_n = 1'b0;
        #1;
        chk({tag, "_state"}, bus.game_state, 0);
        chk({tag, "_title"}, bus.show_title, 1);
        chk({tag, "_score"}, bus.show_score, 0);
        chk({tag, "_gameover"}, bus.show_game_over, 0);
        chk({tag, "_busy"}, bus.digits_busy, 0);
        chk({tag, "_digits"}, {bus.digit_h, bus.digit_t, bus.digit_u}, 24'h303030);
        q.delete();
        last_acc = -1000;
        @(negedge Clk);
        #2 Reset_n = 1'b1;
    endtask

    // Monitor: a busy fall is the "digits valid" event; any other digit change is a partial result.
    always @(negedge Clk) begin
        cur = {bus.digit_h, bus.digit_t, bus.digit_u};
        if (!Reset_n) begin
            prev_busy = 1'b0;
            prev_dig  = 24'h303030;
        end else begin
            if (prev_busy && !bus.digits_busy) begin
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_result actual=%0h required=none", cur);
                end else begin
                    e = q.pop_front();
                    chk("digits", cur, e.dig);
                    chk("latency", cyc - e.c, 10);
                end
            end else if (cur != prev_dig) begin
                total++;
                bad++;
                $display("FAIL partial_digits actual=%0h required=%0h", cur, prev_dig);
            end
            prev_busy = bus.digits_busy;
            prev_dig  = cur;
        end
    end

    initial begin
        bus.frame_clk   = 1'b0;
        bus.start_game  = 1'b0;
        bus.pacman_dead = 1'b0;
        bus.score       = '0;
        Reset_n         = 1'b0;
        repeat (3) @(negedge Clk);
        Reset_n = 1'b1;
        @(negedge Clk);
        chk("rst_state", bus.game_state, 0);
        chk("rst_title", bus.show_title, 1);
        chk("rst_score", bus.show_score, 0);
        chk("rst_gameover", bus.show_game_over, 0);
        chk("rst_digits", {bus.digit_h, bus.digit_t, bus.digit_u}, 24'h303030);
        chk("rst_busy", bus.digits_busy, 0);

        for (int i = 1; i <= 60; i++) begin
            bus.score = 10'($urandom_range(0, 1023));
            do_tick(12);
            if (i == 29 || i == 60) chk($sformatf("blink_on_%0d", i), bus.show_title, 1);
            if (i == 30 || i == 59) chk($sformatf("blink_off_%0d", i), bus.show_title, 0);
        end

        bus.score = 10'd437;  do_tick(12);
        bus.score = 10'd1023; do_tick(12);
        bus.score = 10'd0;    do_tick(12);
        bus.score = 10'd999;  do_tick(12);
        for (int i = 0; i < 20; i++) begin
            bus.score = 10'($urandom_range(0, 1023));
            do_tick($urandom_range(0, 14));
        end
        repeat (12) @(negedge Clk);

        bus.score = 10'd600;
        do_tick(2);
        bus.score = 10'd100;
        do_tick(12);
        repeat (12) @(negedge Clk);

        pulse(1'b1, 1'b0);
        chk("play_state", bus.game_state, 1);
        chk("play_score", bus.show_score, 1);
        chk("play_title", bus.show_title, 0);
        pulse(1'b1, 1'b1);
        chk("go_state", bus.game_state, 2);
        chk("go_banner", bus.show_game_over, 1);
        chk("go_score", bus.show_score, 1);
        pulse(1'b1, 1'b0);
        chk("go_ignore_start", bus.game_state, 2);
        for (int i = 0; i < 179; i++) do_tick(1);
        chk("go_hold_179", bus.game_state, 2);
        do_tick(1);
        chk("go_exit_state", bus.game_state, 0);
        chk("go_exit_title", bus.show_title, 1);
        chk("go_exit_banner", bus.show_game_over, 0);
        repeat (12) @(negedge Clk);

        bus.score = 10'd777; do_tick(12);
        do_tick(3);
        chk("mid_conv_busy", bus.digits_busy, 1);
        async_reset_check("rst_mid_conv");

        pulse(1'b1, 1'b0);
        pulse(1'b0, 1'b1);
        chk("pre_rst_go", bus.game_state, 2);
        async_reset_check("rst_go");

`ifdef HUD_HISCORE_EN
        bus.score = 10'd250; do_tick(12);
        pulse(1'b1, 1'b0);
        pulse(1'b0, 1'b1);
        chk("hi_after_250", {bus.hi_h, bus.hi_t, bus.hi_u}, 24'h323530);
        for (int i = 0; i < 180; i++) do_tick(1);
        repeat (12) @(negedge Clk);
        bus.score = 10'd120; do_tick(12);
        pulse(1'b1, 1'b0);
        pulse(1'b0, 1'b1);
        chk("hi_after_120", {bus.hi_h, bus.hi_t, bus.hi_u}, 24'h323530);
`endif

        for (int i = 0; i < 100 && q.size() != 0; i++) @(negedge Clk);
        chk("drain", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
